// File: rtl/aes256_encrypt_core.sv
// aes256_encrypt_core
// Iterative AES-256 encryption: one cipher round per clock using a latched
// round-key set. Plaintext arrives on a valid/ready handshake and ciphertext
// leaves on a second valid/ready handshake.
//
// Ports:
//   clk                 rising-edge clock
//   reset               asynchronous active-high reset
//   round_keys_i        round keys 0..MAX_ROUND_NUM, [0] = key bits [255:128]
//   round_keys_valid_i  round-key set valid this cycle (sampled in IDLE only)
//   plaintext_i         input block, byte 0 = bits [127:120], column-major
//   plaintext_valid_i   plaintext offered
//   plaintext_ready_o   core accepts plaintext this cycle
//   ciphertext_o        output block, same byte order as plaintext
//   ciphertext_valid_o  ciphertext present (registered)
//   ciphertext_ready_i  downstream accepts ciphertext
module aes256_encrypt_core #(
    parameter int unsigned KEY_WIDTH     = 256,
    parameter int unsigned MAX_ROUND_NUM = 14
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [MAX_ROUND_NUM:0][127:0] round_keys_i,
    input  logic                          round_keys_valid_i,
    input  logic [127:0]                  plaintext_i,
    input  logic                          plaintext_valid_i,
    output logic                          plaintext_ready_o,
    output logic [127:0]                  ciphertext_o,
    output logic                          ciphertext_valid_o,
    input  logic                          ciphertext_ready_i
);

    localparam int unsigned BLK_W   = 128;
    localparam int unsigned ROUND_W = 4;

    // Only the 256-bit key schedule is supported.
    if (KEY_WIDTH != 256) begin : g_key_width_check
        $error("aes256_encrypt_core supports KEY_WIDTH=256 only");
    end

    // FIPS-197 S-box, byte 0x00 at the MSB end.
    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } fsm_t;

    fsm_t                          fsm_q, fsm_d;
    logic [MAX_ROUND_NUM:0][127:0] rk_q, rk_d;
    logic                          keys_loaded, keys_loaded_d;
    logic [BLK_W-1:0]              state_q, state_d;
    logic [ROUND_W-1:0]            round_q, round_d;
    logic                          valid_d;
    logic                          last_round;
    logic [BLK_W-1:0]              round_out;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_FLAT[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // One column of MixColumns; a0 is the top (row 0) byte.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // SubBytes -> ShiftRows -> MixColumns (skipped on the last round) -> AddRoundKey.
    function automatic logic [127:0] enc_round(input logic [127:0] s,
                                               input logic [127:0] rk,
                                               input logic         last);
        logic [0:15][7:0] sb;
        logic [0:15][7:0] sr;
        logic [127:0]     mc;
        sb = s;
        for (int i = 0; i < 16; i++) begin
            sb[i] = sbox(sb[i]);
        end
        // Byte (row r, column c) sits at index r + 4c; row r rotates left by r.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                sr[r + 4 * c] = sb[r + 4 * ((c + r) % 4)];
            end
        end
        mc = sr;
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                mc[127 - 32 * c -: 32] = mix_column(mc[127 - 32 * c -: 32]);
            end
        end
        return mc ^ rk;
    endfunction

    assign last_round = (round_q == ROUND_W'(MAX_ROUND_NUM));
    assign round_out  = enc_round(state_q, rk_q[round_q], last_round);

    // Key load has priority over a plaintext offered in the same cycle.
    assign plaintext_ready_o = (fsm_q == IDLE) && keys_loaded && !round_keys_valid_i;
    assign ciphertext_o      = state_q;

    // Next-state and datapath update.
    always_comb begin
        fsm_d         = fsm_q;
        rk_d          = rk_q;
        keys_loaded_d = keys_loaded;
        state_d       = state_q;
        round_d       = round_q;
        valid_d       = ciphertext_valid_o;
        case (fsm_q)
            IDLE: begin
                if (round_keys_valid_i) begin
                    rk_d          = round_keys_i;
                    keys_loaded_d = 1'b1;
                end else if (plaintext_valid_i && keys_loaded) begin
                    state_d = plaintext_i ^ rk_q[0];
                    round_d = ROUND_W'(1);
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                state_d = round_out;
                if (last_round) begin
                    fsm_d   = DONE;
                    valid_d = 1'b1;
                end else begin
                    round_d = round_q + ROUND_W'(1);
                end
            end
            DONE: begin
                if (ciphertext_ready_i) begin
                    valid_d = 1'b0;
                    fsm_d   = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q              <= IDLE;
            rk_q               <= '0;
            keys_loaded        <= 1'b0;
            state_q            <= '0;
            round_q            <= '0;
            ciphertext_valid_o <= 1'b0;
        end else begin
            fsm_q              <= fsm_d;
            rk_q               <= rk_d;
            keys_loaded        <= keys_loaded_d;
            state_q            <= state_d;
            round_q            <= round_d;
            ciphertext_valid_o <= valid_d;
        end
    end

endmodule

// File: tb/tb_aes256_encrypt_core.sv
// Directed bench for aes256_encrypt_core. Round keys are generated here from
// the cipher key by a small AES-256 key-schedule model (S-box derived from
// the GF(2^8) inverse plus affine map); ciphertexts are published vectors.
module tb_aes256_encrypt_core;

    typedef logic [14:0][127:0] rk_t;

    localparam logic [255:0] KEY1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] KEY2 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] PT2  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CT2  = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;

    logic         clk = 1'b0;
    logic         reset;
    rk_t          round_keys_i;
    logic         round_keys_valid_i;
    logic [127:0] plaintext_i;
    logic         plaintext_valid_i;
    logic         plaintext_ready_o;
    logic [127:0] ciphertext_o;
    logic         ciphertext_valid_o;
    logic         ciphertext_ready_i;

    int           total = 0;
    int           bad   = 0;
    int           xfers = 0;
    logic [7:0]   sb [256];
    rk_t          rk1, rk2;

    aes256_encrypt_core #(
        .KEY_WIDTH     (256),
        .MAX_ROUND_NUM (14)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .round_keys_i       (round_keys_i),
        .round_keys_valid_i (round_keys_valid_i),
        .plaintext_i        (plaintext_i),
        .plaintext_valid_i  (plaintext_valid_i),
        .plaintext_ready_o  (plaintext_ready_o),
        .ciphertext_o       (ciphertext_o),
        .ciphertext_valid_o (ciphertext_valid_o),
        .ciphertext_ready_i (ciphertext_ready_i)
    );

    always #5 clk = ~clk;

    // Count completed ciphertext handshakes.
    always @(posedge clk) begin
        if (ciphertext_valid_o && ciphertext_ready_i) xfers <= xfers + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic rk_t expand(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rk_t         rk;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i - 1];
            if (i % 8 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i - 8] ^ t;
        end
        for (int r = 0; r < 15; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
        return rk;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, t, s;
        for (int b = 0; b < 256; b++) begin
            inv = 8'h00;
            if (b != 0) begin
                inv = 8'h01;
                for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(b));
            end
            s = inv;
            t = inv;
            for (int k = 0; k < 4; k++) begin
                t = {t[6:0], t[7]};
                s = s ^ t;
            end
            sb[b] = s ^ 8'h63;
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_keys(input rk_t rk);
        round_keys_i       = rk;
        round_keys_valid_i = 1'b1;
        tick();
        round_keys_valid_i = 1'b0;
    endtask

    // One block from IDLE: accept, 14 round cycles, optional backpressure,
    // optional key-valid pulse before edge pulse_at, single transfer.
    task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] exp,
                             input int hold, input int pulse_at, input rk_t pulse_keys);
        int x0;
        plaintext_i       = pt;
        plaintext_valid_i = 1'b1;
        #1;
        chk({tag, "_accept_ready"}, 128'(plaintext_ready_o), 128'(1));
        tick();
        plaintext_valid_i = 1'b0;
        chk({tag, "_busy_ready"}, 128'(plaintext_ready_o), 128'(0));
        for (int i = 1; i <= 14; i++) begin
            if (i == pulse_at) begin
                round_keys_i       = pulse_keys;
                round_keys_valid_i = 1'b1;
            end
            tick();
            round_keys_valid_i = 1'b0;
            chk($sformatf("%s_valid_e%0d", tag, i), 128'(ciphertext_valid_o), 128'(i == 14));
        end
        chk({tag, "_ct"}, ciphertext_o, exp);
        plaintext_valid_i = 1'b1;
        #1;
        chk({tag, "_done_ready"}, 128'(plaintext_ready_o), 128'(0));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk($sformatf("%s_hold_ct%0d", tag, i), ciphertext_o, exp);
            chk($sformatf("%s_hold_valid%0d", tag, i), 128'(ciphertext_valid_o), 128'(1));
            chk($sformatf("%s_hold_ready%0d", tag, i), 128'(plaintext_ready_o), 128'(0));
        end
        plaintext_valid_i  = 1'b0;
        x0                 = xfers;
        ciphertext_ready_i = 1'b1;
        tick();
        chk({tag, "_valid_clear"}, 128'(ciphertext_valid_o), 128'(0));
        tick();
        ciphertext_ready_i = 1'b0;
        chk({tag, "_one_xfer"}, 128'(xfers - x0), 128'(1));
    endtask

    initial begin
        reset              = 1'b0;
        round_keys_i       = '0;
        round_keys_valid_i = 1'b0;
        plaintext_i        = '0;
        plaintext_valid_i  = 1'b0;
        ciphertext_ready_i = 1'b0;
        build_sbox();
        rk1 = expand(KEY1);
        rk2 = expand(KEY2);

        // Reset values.
        #2 reset = 1'b1;
        #1;
        chk("rst_ready", 128'(plaintext_ready_o), 128'(0));
        chk("rst_valid", 128'(ciphertext_valid_o), 128'(0));
        chk("rst_ct", ciphertext_o, 128'(0));
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // No keys loaded: plaintext must never be accepted.
        plaintext_i       = PT1;
        plaintext_valid_i = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk($sformatf("nokey_ready%0d", i), 128'(plaintext_ready_o), 128'(0));
            chk($sformatf("nokey_valid%0d", i), 128'(ciphertext_valid_o), 128'(0));
        end

        // First key load while plaintext is still offered.
        round_keys_i       = rk1;
        round_keys_valid_i = 1'b1;
        #1;
        chk("load1_ready", 128'(plaintext_ready_o), 128'(0));
        tick();
        round_keys_valid_i = 1'b0;
        plaintext_valid_i  = 1'b0;

        // FIPS-197 C.3 with exact latency, then with 20 cycles of backpressure.
        run_block("c3", PT1, CT1, 0, 0, rk1);
        run_block("c3_bp", PT1, CT1, 20, 0, rk1);

        // Key load and plaintext together: key wins, no accept.
        round_keys_i       = rk2;
        round_keys_valid_i = 1'b1;
        plaintext_i        = PT2;
        plaintext_valid_i  = 1'b1;
        #1;
        chk("prio_ready", 128'(plaintext_ready_o), 128'(0));
        tick();
        round_keys_valid_i = 1'b0;
        plaintext_valid_i  = 1'b0;
        #1;
        chk("prio_still_idle", 128'(plaintext_ready_o), 128'(1));
        chk("prio_no_valid", 128'(ciphertext_valid_o), 128'(0));

        // SP800-38A ECB-AES256 under the new key; then a key pulse mid-flight.
        run_block("ecb", PT2, CT2, 0, 0, rk2);
        run_block("ecb_pulse", PT2, CT2, 0, 5, rk1);
        run_block("ecb_after", PT2, CT2, 0, 0, rk1);

        // Reset during round 7 discards the block and the keys.
        load_keys(rk1);
        plaintext_i       = PT1;
        plaintext_valid_i = 1'b1;
        tick();
        plaintext_valid_i = 1'b0;
        repeat (6) tick();
        reset = 1'b1;
        #1;
        chk("midrst_ready", 128'(plaintext_ready_o), 128'(0));
        chk("midrst_valid", 128'(ciphertext_valid_o), 128'(0));
        chk("midrst_ct", ciphertext_o, 128'(0));
        tick();
        reset             = 1'b0;
        plaintext_valid_i = 1'b1;
        begin
            int x0;
            x0 = xfers;
            ciphertext_ready_i = 1'b1;
            for (int i = 0; i < 30; i++) begin
                tick();
                chk($sformatf("postrst_valid%0d", i), 128'(ciphertext_valid_o), 128'(0));
                chk($sformatf("postrst_ready%0d", i), 128'(plaintext_ready_o), 128'(0));
            end
            ciphertext_ready_i = 1'b0;
            chk("postrst_no_xfer", 128'(xfers - x0), 128'(0));
        end
        plaintext_valid_i = 1'b0;

        // Fresh keys bring the core back.
        load_keys(rk1);
        run_block("recover", PT1, CT1, 0, 0, rk1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
